multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle MIPS main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback over several clocks, and drives the shared-ALU / single-memory datapath. Memory accesses can stall on a ready handshake, and a retired-instruction counter is provided. Optional ADDI and J support is selected by parameter. Sits between the instruction register opcode field and the multi-cycle datapath muxes and enables.

---
 rtl/multicycle_control_unit_pkg.sv | 52 +++++
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared opcode, ALU-control and mux-select encodings for the multi-cycle MIPS control unit.
package multicycle_control_unit_pkg;

  localparam int unsigned OP_WIDTH  = 6;
  localparam int unsigned SEL_WIDTH = 2;

  localparam logic [OP_WIDTH-1:0] OP_R_FORMAT = 6'b000000;
  localparam logic [OP_WIDTH-1:0] OP_LW       = 6'b100011;
  localparam logic [OP_WIDTH-1:0] OP_SW       = 6'b101011;
  localparam logic [OP_WIDTH-1:0] OP_BEQ      = 6'b000100;
  localparam logic [OP_WIDTH-1:0] OP_J        = 6'b000010;
  localparam logic [OP_WIDTH-1:0] OP_ADDI     = 6'b001000;

  localparam logic [SEL_WIDTH-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [SEL_WIDTH-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [SEL_WIDTH-1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [SEL_WIDTH-1:0] SRC_B_REG     = 2'b00;
  localparam logic [SEL_WIDTH-1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [SEL_WIDTH-1:0] SRC_B_IMM     = 2'b10;
  localparam logic [SEL_WIDTH-1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [SEL_WIDTH-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_WIDTH-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_WIDTH-1:0] PC_SRC_JUMP   = 2'b10;

  // Which flavour of instruction is travelling through MEM_ADDR.
  typedef enum logic [1:0] {
    MEM_KIND_LW,
    MEM_KIND_SW,
    MEM_KIND_ADDI
  } mem_kind_e;

  // Datapath control word driven every cycle.
  typedef struct packed {
    logic                 pc_write;
    logic                 pc_write_cond;
    logic [SEL_WIDTH-1:0] pc_source;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 ir_write;
    logic                 mem_to_reg;
    logic                 reg_dst;
    logic                 reg_write_enable;
    logic                 alu_src_a;
    logic [SEL_WIDTH-1:0] alu_src_b;
    logic [SEL_WIDTH-1:0] alu_op;
    logic                 instr_done;
  } ctl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Opcode/handshake inputs and datapath control outputs of the multi-cycle control unit.
interface multicycle_control_unit_if
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) ();

  logic [OP_WIDTH-1:0]  operation;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic [SEL_WIDTH-1:0] pc_source;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 mem_to_reg;
  logic                 reg_dst;
  logic                 reg_write_enable;
  logic                 alu_src_a;
  logic [SEL_WIDTH-1:0] alu_src_b;
  logic [SEL_WIDTH-1:0] alu_op;
  logic                 instr_done;
  logic                 illegal_op;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    input  operation, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write_enable, alu_src_a,
           alu_src_b, alu_op, instr_done, illegal_op, instr_count
  );

  modport slave (
    output operation, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write_enable, alu_src_a,
           alu_src_b, alu_op, instr_done, illegal_op, instr_count
  );

endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and counts retired instructions.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter bit          USE_MEM_READY = 1'b1,
  parameter bit          ENABLE_ADDI   = 1'b1,
  parameter bit          ENABLE_JUMP   = 1'b1,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC,
    S_R_WB,
    S_ADDI_WB,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_e;

  state_e               state_q, state_d;
  state_e               dec_next;
  mem_kind_e            mem_kind_q, mem_kind_d, dec_kind;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 ready;
  logic                 set_illegal;
  ctl_t                 ctl;

  assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

  // Opcode decode; only consumed in DECODE so operation never reaches the outputs.
  always_comb begin
    dec_next = S_HALT;
    dec_kind = MEM_KIND_LW;
    case (bus.operation)
      OP_R_FORMAT: dec_next = S_EXEC;
      OP_LW:       dec_next = S_MEM_ADDR;
      OP_SW: begin
        dec_next = S_MEM_ADDR;
        dec_kind = MEM_KIND_SW;
      end
      OP_BEQ:      dec_next = S_BRANCH;
      OP_ADDI: begin
        if (ENABLE_ADDI) begin
          dec_next = S_MEM_ADDR;
          dec_kind = MEM_KIND_ADDI;
        end
      end
      OP_J: begin
        if (ENABLE_JUMP) dec_next = S_JUMP;
      end
      default: dec_next = S_HALT;
    endcase
  end

  // Next state and control word.
  always_comb begin
    state_d     = state_q;
    mem_kind_d  = mem_kind_q;
    set_illegal = 1'b0;
    ctl         = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.i_or_d    = 1'b0;
        ctl.alu_src_a = 1'b0;
        ctl.alu_src_b = SRC_B_FOUR;
        ctl.alu_op    = ALU_OP_ADD;
        ctl.pc_source = PC_SRC_ALU;
        if (ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_a = 1'b0;
        ctl.alu_src_b = SRC_B_IMM_SH2;
        ctl.alu_op    = ALU_OP_ADD;
        state_d       = dec_next;
        mem_kind_d    = dec_kind;
        set_illegal   = (dec_next == S_HALT);
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_IMM;
        ctl.alu_op    = ALU_OP_ADD;
        case (mem_kind_q)
          MEM_KIND_LW: state_d = S_MEM_RD;
          MEM_KIND_SW: state_d = S_MEM_WR;
          default:     state_d = S_ADDI_WB;
        endcase
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_dst          = 1'b0;
        ctl.mem_to_reg       = 1'b1;
        ctl.reg_write_enable = 1'b1;
        ctl.instr_done       = 1'b1;
        state_d              = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (ready) begin
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_REG;
        ctl.alu_op    = ALU_OP_FUNCT;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        ctl.reg_dst          = 1'b1;
        ctl.reg_write_enable = 1'b1;
        ctl.instr_done       = 1'b1;
        state_d              = S_FETCH;
      end
      S_ADDI_WB: begin
        ctl.reg_dst          = 1'b0;
        ctl.mem_to_reg       = 1'b0;
        ctl.reg_write_enable = 1'b1;
        ctl.instr_done       = 1'b1;
        state_d              = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRC_B_REG;
        ctl.alu_op        = ALU_OP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PC_SRC_ALUOUT;
        ctl.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PC_SRC_JUMP;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // State register plus the instruction kind captured in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_kind_q <= MEM_KIND_LW;
    end else begin
      state_q    <= state_d;
      mem_kind_q <= mem_kind_d;
    end
  end

  // Sticky illegal flag and free-running retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (set_illegal)    illegal_q <= 1'b1;
      if (ctl.instr_done) count_q   <= count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.pc_write         = ctl.pc_write;
  assign bus.pc_write_cond    = ctl.pc_write_cond;
  assign bus.pc_source        = ctl.pc_source;
  assign bus.i_or_d           = ctl.i_or_d;
  assign bus.mem_read         = ctl.mem_read;
  assign bus.mem_write        = ctl.mem_write;
  assign bus.ir_write         = ctl.ir_write;
  assign bus.mem_to_reg       = ctl.mem_to_reg;
  assign bus.reg_dst          = ctl.reg_dst;
  assign bus.reg_write_enable = ctl.reg_write_enable;
  assign bus.alu_src_a        = ctl.alu_src_a;
  assign bus.alu_src_b        = ctl.alu_src_b;
  assign bus.alu_op           = ctl.alu_op;
  assign bus.instr_done       = ctl.instr_done;
  assign bus.illegal_op       = illegal_q;
  assign bus.instr_count      = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: opcode latency table, directed corner sequences and
// a randomized instruction stream checked against a phase-list reference model.
module tb_multicycle_control_unit;

  localparam logic [5:0] R_OP    = 6'b000000;
  localparam logic [5:0] LW_OP   = 6'b100011;
  localparam logic [5:0] SW_OP   = 6'b101011;
  localparam logic [5:0] BEQ_OP  = 6'b000100;
  localparam logic [5:0] J_OP    = 6'b000010;
  localparam logic [5:0] ADDI_OP = 6'b001000;
  localparam logic [5:0] BAD_OP  = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write_enable;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctl_t;

  typedef enum {P_FW, P_FD, P_DEC, P_MA, P_MRD, P_MWB, P_MWR, P_MWRD,
                P_EX, P_RWB, P_AWB, P_BR, P_J} ph_e;

  typedef struct { logic [5:0] op; int cycles; bit illegal; } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned model_cnt = 0;
  vec_t        tbl [8];
  logic [5:0]  legal [6];
  logic [5:0]  seq3 [4];
  int          exp3 [4];
  int          got3 [4];
  int          idx, n, held, done_c;
  bit          seen;
  ctl_t        act_a, act_b;

  multicycle_control_unit_if ifa ();
  multicycle_control_unit_if #(.CNT_WIDTH(2)) ifb ();

  multicycle_control_unit dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  multicycle_control_unit #(.ENABLE_JUMP(1'b0), .CNT_WIDTH(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  assign act_a = {ifa.pc_write, ifa.pc_write_cond, ifa.pc_source, ifa.i_or_d, ifa.mem_read,
                  ifa.mem_write, ifa.ir_write, ifa.mem_to_reg, ifa.reg_dst, ifa.reg_write_enable,
                  ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op, ifa.instr_done};
  assign act_b = {ifb.pc_write, ifb.pc_write_cond, ifb.pc_source, ifb.i_or_d, ifb.mem_read,
                  ifb.mem_write, ifb.ir_write, ifb.mem_to_reg, ifb.reg_dst, ifb.reg_write_enable,
                  ifb.alu_src_a, ifb.alu_src_b, ifb.alu_op, ifb.instr_done};

  // Expected control word for each phase of an instruction.
  function automatic ctl_t ph(input ph_e p);
    ctl_t c = '0;
    case (p)
      P_FW:   begin c.mem_read = 1; c.alu_src_b = 2'b01; end
      P_FD:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_write = 1; end
      P_DEC:  c.alu_src_b = 2'b11;
      P_MA:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      P_MRD:  begin c.mem_read = 1; c.i_or_d = 1; end
      P_MWB:  begin c.mem_to_reg = 1; c.reg_write_enable = 1; c.instr_done = 1; end
      P_MWR:  begin c.mem_write = 1; c.i_or_d = 1; end
      P_MWRD: begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = 1; end
      P_EX:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      P_RWB:  begin c.reg_dst = 1; c.reg_write_enable = 1; c.instr_done = 1; end
      P_AWB:  begin c.reg_write_enable = 1; c.instr_done = 1; end
      P_BR:   begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                    c.pc_source = 2'b01; c.instr_done = 1; end
      P_J:    begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, outputs settle 1 unit later.
  task automatic step(input bit rdy, input logic [5:0] op);
    @(negedge clk);
    ifa.mem_ready = rdy;
    ifb.mem_ready = rdy;
    ifa.operation = op;
    ifb.operation = op;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_ctl_a", 64'(act_a), 64'(0));
    chk("reset_count_a", 64'(ifa.instr_count), 64'(0));
    chk("reset_illegal_a", 64'(ifa.illegal_op), 64'(0));
    chk("reset_count_b", 64'(ifb.instr_count), 64'(0));
    chk("reset_illegal_b", 64'(ifb.illegal_op), 64'(0));
    model_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic cmp_cycle(input ctl_t exp);
    chk("rand_ctl", 64'(act_a), 64'(exp));
    chk("rand_count", 64'(ifa.instr_count), 64'(model_cnt));
    chk("rand_illegal", 64'(ifa.illegal_op), 64'(0));
    if (exp.instr_done) model_cnt++;
  endtask

  // Memory phase: random stalls, forced completion after 4 waits.
  task automatic mphase(input ph_e wait_p, input ph_e done_p, input logic [5:0] op);
    int w = 0;
    bit rdy;
    do begin
      rdy = (w >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
      step(rdy, op);
      cmp_cycle(rdy ? ph(done_p) : ph(wait_p));
      if (!rdy) w++;
    end while (!rdy);
  endtask

  task automatic pphase(input ph_e p, input logic [5:0] op);
    step(1'($urandom_range(0, 1)), op);
    cmp_cycle(ph(p));
  endtask

  task automatic run_model(input logic [5:0] op);
    mphase(P_FW, P_FD, 6'($urandom));
    pphase(P_DEC, op);
    case (op)
      R_OP:    begin pphase(P_EX, op); pphase(P_RWB, op); end
      LW_OP:   begin pphase(P_MA, op); mphase(P_MRD, P_MRD, op); pphase(P_MWB, op); end
      SW_OP:   begin pphase(P_MA, op); mphase(P_MWR, P_MWRD, op); end
      ADDI_OP: begin pphase(P_MA, op); pphase(P_AWB, op); end
      BEQ_OP:  pphase(P_BR, op);
      default: pphase(P_J, op);
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.mem_ready = 1'b0; ifb.mem_ready = 1'b0;
    ifa.operation = '0;   ifb.operation = '0;
    tbl[0] = '{R_OP, 4, 1'b0};    tbl[1] = '{LW_OP, 5, 1'b0};
    tbl[2] = '{SW_OP, 4, 1'b0};   tbl[3] = '{ADDI_OP, 4, 1'b0};
    tbl[4] = '{BEQ_OP, 3, 1'b0};  tbl[5] = '{J_OP, 3, 1'b0};
    tbl[6] = '{BAD_OP, 0, 1'b1};  tbl[7] = '{6'b000001, 0, 1'b1};
    legal = '{R_OP, LW_OP, SW_OP, ADDI_OP, BEQ_OP, J_OP};
    seq3 = '{SW_OP, BEQ_OP, J_OP, ADDI_OP};
    exp3 = '{4, 7, 10, 14};
    #3;

    // Zero-wait latency per opcode, FETCH counted as cycle 1.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      step(1'b1, tbl[i].op);
      n = 0; seen = 0;
      for (int c = 1; c <= 8 && !seen; c++) begin
        step(1'b1, tbl[i].op);
        n = c;
        if (act_a.instr_done) seen = 1;
      end
      if (tbl[i].illegal) begin
        chk("tbl_halt_done", 64'(seen), 64'(0));
        chk("tbl_halt_illegal", 64'(ifa.illegal_op), 64'(1));
        chk("tbl_halt_quiet", 64'(act_a), 64'(0));
      end else begin
        chk("tbl_cycles", 64'(n), 64'(tbl[i].cycles));
        step(1'b1, tbl[i].op);
        chk("tbl_count", 64'(ifa.instr_count), 64'(1));
      end
    end

    // R retires at cycle 5 counting the IDLE cycle.
    do_reset();
    done_c = 0;
    for (int c = 1; c <= 10 && done_c == 0; c++) begin
      step(1'b1, R_OP);
      if (act_a.instr_done) begin
        done_c = c;
        chk("r_wb_ctl", 64'({ifa.reg_write_enable, ifa.reg_dst}), 64'(2'b11));
      end
    end
    chk("r_done_cycle", 64'(done_c), 64'(5));
    step(1'b1, R_OP);
    chk("r_count", 64'(ifa.instr_count), 64'(1));

    // LW with 3 stall cycles in MEM_RD.
    do_reset();
    step(1'b1, LW_OP);
    held = 0; done_c = 0;
    for (int c = 1; c <= 12 && done_c == 0; c++) begin
      step(!(c >= 4 && c <= 6), LW_OP);
      if (ifa.mem_read && ifa.i_or_d) held++;
      if (act_a.instr_done) done_c = c;
    end
    chk("lw_held", 64'(held), 64'(4));
    chk("lw_done_cycle", 64'(done_c), 64'(8));

    // SW, BEQ, J, ADDI back to back.
    do_reset();
    step(1'b1, SW_OP);
    idx = 0; got3 = '{0, 0, 0, 0};
    for (int c = 1; c <= 14; c++) begin
      step(1'b1, seq3[idx < 4 ? idx : 0]);
      if (act_a.instr_done && idx < 4) begin got3[idx] = c; idx++; end
    end
    for (int i = 0; i < 4; i++) chk("seq_done_cycle", 64'(got3[i]), 64'(exp3[i]));
    step(1'b1, R_OP);
    chk("seq_count", 64'(ifa.instr_count), 64'(4));

    // Illegal opcode halts and stays quiet until reset.
    do_reset();
    step(1'b1, R_OP);
    step(1'b1, 6'($urandom));
    step(1'b1, BAD_OP);
    for (int k = 0; k < 5; k++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom));
      chk("halt_quiet", 64'(act_a), 64'(0));
      chk("halt_sticky", 64'(ifa.illegal_op), 64'(1));
    end

    // J with jumps disabled (instance B) vs enabled (instance A).
    do_reset();
    step(1'b1, J_OP);
    step(1'b1, J_OP);
    step(1'b1, J_OP);
    step(1'b1, J_OP);
    chk("b_j_illegal", 64'(ifb.illegal_op), 64'(1));
    chk("b_j_quiet", 64'(act_b), 64'(0));
    chk("a_j_legal", 64'(ifa.illegal_op), 64'(0));
    chk("a_j_ctl", 64'(act_a), 64'(ph(P_J)));

    // Five R instructions wrap the 2-bit counter.
    do_reset();
    step(1'b1, R_OP);
    for (int k = 0; k < 20; k++) step(1'b1, R_OP);
    step(1'b1, R_OP);
    chk("b_wrap", 64'(ifb.instr_count), 64'(1));
    chk("a_count5", 64'(ifa.instr_count), 64'(5));

    // Asynchronous reset in the middle of a stalled store.
    do_reset();
    step(1'b1, R_OP);
    for (int k = 0; k < 4; k++) step(1'b1, R_OP);
    step(1'b1, SW_OP);
    step(1'b1, SW_OP);
    step(1'b1, SW_OP);
    step(1'b0, SW_OP);
    chk("mwr_before", 64'({ifa.mem_write, ifa.i_or_d}), 64'(2'b11));
    chk("mwr_count_before", 64'(ifa.instr_count), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mwr_async_drop", 64'(ifa.mem_write), 64'(0));
    chk("mwr_async_count", 64'(ifa.instr_count), 64'(0));

    // Randomized instruction stream against the phase model.
    do_reset();
    step(1'($urandom_range(0, 1)), 6'($urandom));
    cmp_cycle(ph(P_FW) & '0);
    for (int k = 0; k < 40; k++) run_model(legal[$urandom_range(0, 5)]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
